// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder block.
// Optional build macro used by fft_reorder: FFT_REORDER_BIN_IDX_EN.
package fft_pkg;

  // Default width of each real/imag component.
  localparam int unsigned WidthDefault = 16;

  // Widest address the bit-reverse helper supports (N up to 4096).
  localparam int unsigned BitrevMaxW = 12;

  // Read-side FSM states.
  typedef enum logic {
    StIdle,
    StRead
  } rd_state_e;

  // Reverse the low log2n bits of value; upper result bits are zero.
  function automatic logic [BitrevMaxW-1:0] bitrev(input logic [BitrevMaxW-1:0] value,
                                                   input int unsigned log2n);
    logic [BitrevMaxW-1:0] rev;
    rev = '0;
    for (int i = 0; i < int'(BitrevMaxW); i++) begin
      if (i < int'(log2n)) begin
        rev[i] = value[int'(log2n) - 1 - i];
      end
    end
    return rev;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM with registered read, written for block-RAM inference.
// The address MSB selects the ping-pong bank; contents are never reset.
module fft_reorder_ram
  import fft_pkg::*;
#(
  parameter int unsigned Depth = 128,
  parameter int unsigned DataW = 32,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rdata_q;

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; reads every cycle, the consumer qualifies the data.
  always_ff @(posedge clk_i) begin
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fft_reorder.sv
// Bit-reversed to natural-order reorder buffer for the SDF FFT output stream.
// Ping-pong pair of N-entry banks; output is valid-only, no backpressure.
// Optional build macro: FFT_REORDER_BIN_IDX_EN adds the out_idx bin index port.
module fft_reorder
  import fft_pkg::*;
#(
  parameter int unsigned N     = 64,
  parameter int unsigned WIDTH = fft_pkg::WidthDefault,
  localparam int unsigned LOG2N = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_in,
  input  logic [WIDTH-1:0] in_re,
  input  logic [WIDTH-1:0] in_im,
  output logic             enable_out,
  output logic [WIDTH-1:0] out_re,
  output logic [WIDTH-1:0] out_im,
  output logic             frame_start
`ifdef FFT_REORDER_BIN_IDX_EN
  ,
  output logic [LOG2N-1:0] out_idx
`endif
);

  // Write side state.
  logic [LOG2N-1:0] wcnt_q, wcnt_d;
  logic             wbank_q, wbank_d;
  logic             rbank_next_q, rbank_next_d;
  logic             frame_done;

  // Read side state.
  rd_state_e        state_q, state_d;
  logic [LOG2N-1:0] rcnt_q, rcnt_d;
  logic             rbank_q, rbank_d;
  logic             pend_q, pend_d;
  logic             rd_active;

  // RAM-read pipeline stage and output registers.
  logic             rd_valid_q, rd_valid_d;
  logic             rd_first_q, rd_first_d;
  logic             enable_out_q, enable_out_d;
  logic             frame_start_q, frame_start_d;
  logic [WIDTH-1:0] out_re_q, out_re_d;
  logic [WIDTH-1:0] out_im_q, out_im_d;
`ifdef FFT_REORDER_BIN_IDX_EN
  logic [LOG2N-1:0] rd_idx_q, rd_idx_d;
  logic [LOG2N-1:0] out_idx_q, out_idx_d;
`endif

  logic [BitrevMaxW-1:0] wr_rev;
  logic [LOG2N-1:0]      wr_addr;
  logic [2*WIDTH-1:0]    rdata;
  logic                  unused_wr_rev;

  assign wr_rev        = bitrev(BitrevMaxW'(wcnt_q), LOG2N);
  assign wr_addr       = wr_rev[LOG2N-1:0];
  assign unused_wr_rev = ^wr_rev;

  fft_reorder_ram #(
    .Depth(2 * N),
    .DataW(2 * WIDTH)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (enable_in),
    .waddr_i({wbank_q, wr_addr}),
    .wdata_i({in_re, in_im}),
    .raddr_i({rbank_q, rcnt_q}),
    .rdata_o(rdata)
  );

  // Write counter/bank; frame_done marks acceptance of the last sample of a frame.
  always_comb begin
    frame_done   = enable_in && (wcnt_q == '1);
    wcnt_d       = wcnt_q;
    wbank_d      = wbank_q;
    rbank_next_d = rbank_next_q;
    if (enable_in) begin
      wcnt_d = wcnt_q + LOG2N'(1);
    end
    if (frame_done) begin
      wbank_d      = ~wbank_q;
      rbank_next_d = wbank_q;
    end
  end

  // Read FSM: one natural-order frame per N READ cycles, chaining frames without a gap.
  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    rbank_d   = rbank_q;
    pend_d    = pend_q;
    rd_active = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_done) begin
          state_d = StRead;
          rcnt_d  = '0;
          rbank_d = rbank_next_d;
        end
      end
      StRead: begin
        rd_active = 1'b1;
        rcnt_d    = rcnt_q + LOG2N'(1);
        if (rcnt_q == '1) begin
          if (frame_done || pend_q) begin
            rcnt_d  = '0;
            rbank_d = rbank_next_d;
            pend_d  = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end else if (frame_done) begin
          pend_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output pipeline: qualifies the registered RAM data; data holds while idle.
  always_comb begin
    rd_valid_d    = rd_active;
    rd_first_d    = rd_active && (rcnt_q == '0);
    enable_out_d  = rd_valid_q;
    frame_start_d = rd_first_q;
    out_re_d      = out_re_q;
    out_im_d      = out_im_q;
    if (rd_valid_q) begin
      out_re_d = rdata[2*WIDTH-1:WIDTH];
      out_im_d = rdata[WIDTH-1:0];
    end
`ifdef FFT_REORDER_BIN_IDX_EN
    rd_idx_d  = rcnt_q;
    out_idx_d = out_idx_q;
    if (rd_valid_q) begin
      out_idx_d = rd_idx_q;
    end
`endif
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q        <= '0;
      wbank_q       <= 1'b0;
      rbank_next_q  <= 1'b0;
      state_q       <= StIdle;
      rcnt_q        <= '0;
      rbank_q       <= 1'b0;
      pend_q        <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_first_q    <= 1'b0;
      enable_out_q  <= 1'b0;
      frame_start_q <= 1'b0;
      out_re_q      <= '0;
      out_im_q      <= '0;
`ifdef FFT_REORDER_BIN_IDX_EN
      rd_idx_q      <= '0;
      out_idx_q     <= '0;
`endif
    end else begin
      wcnt_q        <= wcnt_d;
      wbank_q       <= wbank_d;
      rbank_next_q  <= rbank_next_d;
      state_q       <= state_d;
      rcnt_q        <= rcnt_d;
      rbank_q       <= rbank_d;
      pend_q        <= pend_d;
      rd_valid_q    <= rd_valid_d;
      rd_first_q    <= rd_first_d;
      enable_out_q  <= enable_out_d;
      frame_start_q <= frame_start_d;
      out_re_q      <= out_re_d;
      out_im_q      <= out_im_d;
`ifdef FFT_REORDER_BIN_IDX_EN
      rd_idx_q      <= rd_idx_d;
      out_idx_q     <= out_idx_d;
`endif
    end
  end

  assign enable_out  = enable_out_q;
  assign frame_start = frame_start_q;
  assign out_re      = out_re_q;
  assign out_im      = out_im_q;
`ifdef FFT_REORDER_BIN_IDX_EN
  assign out_idx     = out_idx_q;
`endif

endmodule

// File: tb/tb_fft_reorder.sv
// Self-checking bench for fft_reorder with a natural-order scoreboard.
// With FFT_REORDER_BIN_IDX_EN defined it runs N=8 and also checks out_idx.
module tb_fft_reorder;

`ifdef FFT_REORDER_BIN_IDX_EN
  localparam int N = 8;
`else
  localparam int N = 64;
`endif
  localparam int W = 16;
  localparam int LOG2N = $clog2(N);

  logic clk;
  logic rst_n;
  logic enable_in;
  logic [W-1:0] in_re, in_im;
  logic enable_out;
  logic [W-1:0] out_re, out_im;
  logic frame_start;
`ifdef FFT_REORDER_BIN_IDX_EN
  logic [LOG2N-1:0] out_idx;
`endif

  typedef struct packed {
    logic [W-1:0]     re;
    logic [W-1:0]     im;
    logic             fs;
    logic [LOG2N-1:0] idx;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  int fs_cnt = 0;
  int run = 0;
  int max_run = 0;

  fft_reorder #(
    .N    (N),
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_in  (enable_in),
    .in_re      (in_re),
    .in_im      (in_im),
    .enable_out (enable_out),
    .out_re     (out_re),
    .out_im     (out_im),
    .frame_start(frame_start)
`ifdef FFT_REORDER_BIN_IDX_EN
    ,
    .out_idx    (out_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  function automatic int tb_bitrev(input int k);
    int r;
    r = 0;
    for (int i = 0; i < LOG2N; i++) begin
      r = r | (((k >> i) & 1) << (LOG2N - 1 - i));
    end
    return r;
  endfunction

  // Scoreboard monitor: every valid output beat must match the next expected bin.
  always @(negedge clk) begin
    if (rst_n && enable_out) begin
      out_cnt++;
      run++;
      if (run > max_run) max_run = run;
      if (frame_start) fs_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got re=%0d im=%0d fs=%0b, required no output",
                 out_re, out_im, frame_start);
      end else begin
        mon_e = sb.pop_front();
        if ({out_re, out_im, frame_start} !== {mon_e.re, mon_e.im, mon_e.fs}) begin
          errors++;
          $display("FAIL output_bin: got re=%0d im=%0d fs=%0b, required re=%0d im=%0d fs=%0b",
                   out_re, out_im, frame_start, mon_e.re, mon_e.im, mon_e.fs);
        end
`ifdef FFT_REORDER_BIN_IDX_EN
        checks++;
        if (out_idx !== mon_e.idx) begin
          errors++;
          $display("FAIL out_idx: got %0d, required %0d", out_idx, mon_e.idx);
        end
`endif
      end
    end else begin
      run = 0;
    end
  end

  task automatic clear_counts();
    @(posedge clk);
    #1;
    out_cnt = 0;
    fs_cnt  = 0;
    max_run = 0;
  endtask

  // Drives N-sample-style stream; pushes the natural-order frame when its last sample is driven.
  task automatic send_frame(input int base, input int gap_every, input int gap_len,
                            input int nsamp);
    exp_t e;
    for (int k = 0; k < nsamp; k++) begin
      if (gap_every > 0 && k > 0 && (k % gap_every) == 0) begin
        repeat (gap_len) begin
          @(posedge clk);
          #1;
          enable_in = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      enable_in = 1'b1;
      in_re     = W'(tb_bitrev(k) + base);
      in_im     = W'(-(tb_bitrev(k) + base));
      if (k == N - 1) begin
        for (int b = 0; b < N; b++) begin
          e.re  = W'(b + base);
          e.im  = W'(-(b + base));
          e.fs  = (b == 0);
          e.idx = LOG2N'(b);
          sb.push_back(e);
        end
      end
    end
  endtask

  // The posedge here accepts the last driven sample (edge T).
  task automatic finish_input();
    @(posedge clk);
    #1;
    enable_in = 1'b0;
  endtask

  // Edges after T until enable_out is first seen; -1 when it never appears.
  task automatic measure_latency(output int lat, output logic fs_first);
    lat = -1;
    fs_first = 1'b0;
    for (int c = 1; c <= 4 * N + 10; c++) begin
      @(negedge clk);
      if (enable_out) begin
        lat = c - 1;
        fs_first = frame_start;
        break;
      end
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8 * N + 20; i++) begin
      @(posedge clk);
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable_in = 1'b1;
    in_re = 16'h1234;
    in_im = 16'h5678;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({enable_out, frame_start, out_re, out_im} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%0b fs=%0b re=%0d im=%0d, required all 0",
               enable_out, frame_start, out_re, out_im);
    end
`ifdef FFT_REORDER_BIN_IDX_EN
    checks++;
    if (out_idx !== '0) begin
      errors++;
      $display("FAIL reset_out_idx: got %0d, required 0", out_idx);
    end
`endif
    enable_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (N + 4) @(posedge clk);
    #1;
    checks++;
    if (enable_out !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got en=%0b, required 0", enable_out);
    end
  endtask

  task automatic check_one_frame(input string name, input int gap_every, input int gap_len);
    int lat;
    logic fs_first;
    bit ok;
    clear_counts();
    send_frame(0, gap_every, gap_len, N);
    finish_input();
    measure_latency(lat, fs_first);
    checks++;
    if (lat != 2 || fs_first !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges fs=%0b, required 2 edges fs=1", name, lat, fs_first);
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_drain: got %0d bins outstanding, required 0", name, sb.size());
    end
    checks++;
    if (out_cnt != N || max_run != N || fs_cnt != 1) begin
      errors++;
      $display("FAIL %s_count: got beats=%0d run=%0d starts=%0d, required %0d %0d 1",
               name, out_cnt, max_run, fs_cnt, N, N);
    end
    checks++;
    if (enable_out !== 1'b0 || out_re !== W'(N - 1) || out_im !== W'(-(N - 1))) begin
      errors++;
      $display("FAIL %s_hold: got en=%0b re=%0d im=%0d, required en=0 re=%0d im=%0d",
               name, enable_out, out_re, out_im, W'(N - 1), W'(-(N - 1)));
    end
  endtask

  task automatic test_single_frame();
    check_one_frame("single", 0, 0);
  endtask

  task automatic test_gapped();
    check_one_frame("gapped", 5, 3);
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_counts();
    for (int f = 0; f < 3; f++) begin
      send_frame(64 * f, 0, 0, N);
    end
    finish_input();
    wait_drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_drain: got %0d bins outstanding, required 0", sb.size());
    end
    checks++;
    if (out_cnt != 3 * N || max_run != 3 * N || fs_cnt != 3) begin
      errors++;
      $display("FAIL b2b_count: got beats=%0d run=%0d starts=%0d, required %0d %0d 3",
               out_cnt, max_run, fs_cnt, 3 * N, 3 * N);
    end
  endtask

  task automatic test_reset_mid_frame();
    int lat;
    logic fs_first;
    bit ok;
    clear_counts();
    send_frame(500, 0, 0, (N > 20) ? 20 : N / 2);
    finish_input();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_frame(300, 0, 0, N);
    finish_input();
    measure_latency(lat, fs_first);
    checks++;
    if (lat != 2 || fs_first !== 1'b1) begin
      errors++;
      $display("FAIL rst_frame_latency: got %0d edges fs=%0b, required 2 edges fs=1",
               lat, fs_first);
    end
    wait_drain(ok);
    checks++;
    if (!ok || out_cnt != N) begin
      errors++;
      $display("FAIL rst_frame_count: got beats=%0d outstanding=%0d, required %0d and 0",
               out_cnt, sb.size(), N);
    end
  endtask

  task automatic test_reset_mid_read();
    int rbin;
    bit found;
    bit ok;
    rbin = (N > 30) ? 30 : N / 2;
    send_frame(0, 0, 0, N);
    finish_input();
    found = 1'b0;
    for (int i = 0; i < 4 * N + 10; i++) begin
      @(negedge clk);
      if (enable_out && out_re == W'(rbin)) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL read_reach_bin: got no bin %0d, required it to appear", rbin);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (enable_out !== 1'b0 || out_re !== '0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL read_async_clear: got en=%0b re=%0d fs=%0b, required 0 0 0",
               enable_out, out_re, frame_start);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    repeat (3 * N) @(posedge clk);
    #1;
    checks++;
    if (out_cnt != 0) begin
      errors++;
      $display("FAIL read_no_resume: got %0d beats after reset, required 0", out_cnt);
    end
    send_frame(700, 0, 0, N);
    finish_input();
    wait_drain(ok);
    checks++;
    if (!ok || out_cnt != N) begin
      errors++;
      $display("FAIL read_new_frame: got beats=%0d outstanding=%0d, required %0d and 0",
               out_cnt, sb.size(), N);
    end
  endtask

`ifdef FFT_REORDER_BIN_IDX_EN
  task automatic test_bin_idx();
    bit ok;
    clear_counts();
    send_frame(0, 0, 0, N);
    finish_input();
    wait_drain(ok);
    checks++;
    if (!ok || out_cnt != N) begin
      errors++;
      $display("FAIL bin_idx_frame: got beats=%0d outstanding=%0d, required %0d and 0",
               out_cnt, sb.size(), N);
    end
    checks++;
    if (out_idx !== LOG2N'(N - 1)) begin
      errors++;
      $display("FAIL bin_idx_hold: got %0d, required %0d", out_idx, N - 1);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    enable_in = 1'b0;
    in_re = '0;
    in_im = '0;
    test_reset();
    test_single_frame();
    test_gapped();
    test_back_to_back();
    test_reset_mid_frame();
    test_reset_mid_read();
`ifdef FFT_REORDER_BIN_IDX_EN
    test_bin_idx();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
